// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller: fetches a 10-bit instruction over req/ack, decodes it and
// drives the PC control inputs, register-file/ALU strobes and data-memory handshake.
module instruction_sequencer (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       RUN,
    output logic       IMEM_REQ,
    input  logic       IMEM_ACK,
    input  logic [9:0] IMEM_DATA,
    output logic       DMEM_REQ,
    input  logic       DMEM_ACK,
    output logic       PC_EN,
    output logic       PL,
    output logic       JB,
    output logic       BC,
    output logic [1:0] LADDRESS,
    output logic [1:0] RADDRESS,
    output logic [1:0] DA,
    output logic [1:0] AA,
    output logic [1:0] BA,
    output logic [2:0] FS,
    output logic       RW,
    output logic       MW,
    output logic       MD,
    output logic       HALTED,
    output logic       ILLEGAL
);

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalt} state_e;

    localparam logic [3:0] OpNop  = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpSub  = 4'b0010;
    localparam logic [3:0] OpAnd  = 4'b0011;
    localparam logic [3:0] OpOr   = 4'b0100;
    localparam logic [3:0] OpLd   = 4'b0101;
    localparam logic [3:0] OpSt   = 4'b0110;
    localparam logic [3:0] OpBrz  = 4'b1000;
    localparam logic [3:0] OpBrn  = 4'b1001;
    localparam logic [3:0] OpJmp  = 4'b1010;
    localparam logic [3:0] OpHalt = 4'b1111;

    state_e     state_q, state_d;
    logic [9:0] ir_q, ir_d;
    logic       illegal_q, illegal_d;
    logic [3:0] opcode;

    assign opcode = ir_q[9:6];

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OpNop, OpAdd, OpSub, OpAnd, OpOr, OpLd, OpSt,
            OpBrz, OpBrn, OpJmp, OpHalt: is_legal = 1'b1;
            default:                     is_legal = 1'b0;
        endcase
    endfunction

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            StIdle: begin
                if (RUN) state_d = StFetch;
            end
            StFetch: begin
                if (IMEM_ACK) begin
                    ir_d    = IMEM_DATA;
                    state_d = StExec;
                    // Flag on latch so ILLEGAL is already visible in the EXEC cycle.
                    if (!is_legal(IMEM_DATA[9:6])) illegal_d = 1'b1;
                end
            end
            StExec: begin
                if (opcode == OpLd || opcode == OpSt) state_d = StMem;
                else if (opcode == OpHalt)            state_d = StHalt;
                else                                  state_d = RUN ? StFetch : StIdle;
            end
            StMem: begin
                if (DMEM_ACK) state_d = RUN ? StFetch : StIdle;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        IMEM_REQ = 1'b0;
        DMEM_REQ = 1'b0;
        PC_EN    = 1'b0;
        PL       = 1'b0;
        JB       = 1'b0;
        BC       = 1'b0;
        FS       = 3'b000;
        RW       = 1'b0;
        MW       = 1'b0;
        MD       = 1'b0;
        HALTED   = 1'b0;
        case (state_q)
            StFetch: IMEM_REQ = 1'b1;
            StExec: begin
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpOr: begin
                        RW    = 1'b1;
                        PC_EN = 1'b1;
                        FS    = opcode[2:0];
                    end
                    OpLd, OpSt, OpHalt: ;
                    OpBrz: begin
                        PC_EN = 1'b1;
                        PL    = 1'b1;
                    end
                    OpBrn: begin
                        PC_EN = 1'b1;
                        PL    = 1'b1;
                        BC    = 1'b1;
                    end
                    OpJmp: begin
                        PC_EN = 1'b1;
                        PL    = 1'b1;
                        JB    = 1'b1;
                    end
                    default: PC_EN = 1'b1;
                endcase
            end
            StMem: begin
                DMEM_REQ = 1'b1;
                MD       = (opcode == OpLd);
                MW       = (opcode == OpSt);
                if (DMEM_ACK) begin
                    PC_EN = 1'b1;
                    RW    = (opcode == OpLd);
                end
            end
            StHalt: HALTED = 1'b1;
            default: ;
        endcase
    end

    assign DA       = ir_q[5:4];
    assign AA       = ir_q[3:2];
    assign BA       = ir_q[1:0];
    assign LADDRESS = ir_q[5:4];
    assign RADDRESS = ir_q[1:0];
    assign ILLEGAL  = illegal_q;

endmodule
